// File: rtl/mem_multi_bank_clr.sv
// mem_multi_bank_clr: NUM_BANKS simple-dual-port RAM banks that share one
// write port and one read port. The read latency is selectable, and a clear
// engine rewrites one bank at a time to DEFAULT_VALUE, one entry per cycle.
// Ports: clk, reset (synchronous, active high).
//   Write port:   wea, banka, addra, dia.
//   Read port:    reb, bankb, addrb -> dob, dob_valid.
//   Clear engine: clear_req, clear_bank -> clear_busy, clear_done.
//   wr_dropped:   pulses when a user write is discarded.
// Option: define MEM_MULTI_BANK_CLR_BYPASS_EN to forward a write to a
//   same-cycle read of the same location. Without it, reads are read-first.
module mem_multi_bank_clr #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int NUM_BANKS     = 2,
   parameter int BANK_WIDTH    = $clog2(NUM_BANKS),
   parameter int OUTPUT_DELAY  = 1,
   parameter int DEFAULT_VALUE = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wea,
   input  logic [BANK_WIDTH-1:0]    banka,
   input  logic [$clog2(DEPTH)-1:0] addra,
   input  logic [DATA_WIDTH-1:0]    dia,
   input  logic                     reb,
   input  logic [BANK_WIDTH-1:0]    bankb,
   input  logic [$clog2(DEPTH)-1:0] addrb,
   output logic [DATA_WIDTH-1:0]    dob,
   output logic                     dob_valid,
   input  logic                     clear_req,
   input  logic [BANK_WIDTH-1:0]    clear_bank,
   output logic                     clear_busy,
   output logic                     clear_done,
   output logic                     wr_dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [DATA_WIDTH-1:0] DEF = DATA_WIDTH'(DEFAULT_VALUE);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                state_q, state_n;
   logic [AW-1:0]         cnt_q, cnt_n;
   logic [BANK_WIDTH-1:0] cbank_q, cbank_n;
   logic                  done_q, done_n;
   logic                  clr_act;

   logic [DATA_WIDTH-1:0] bank_out [NUM_BANKS];

   // ---------------- clear engine: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cbank_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         cbank_q <= cbank_n;
         done_q  <= done_n;
      end
   end

   // ---------------- clear engine: next state ----------------
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      cbank_n = cbank_q;
      done_n  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               state_n = S_CLEAR;
               cnt_n   = '0;
               cbank_n = clear_bank;
            end
         end
         S_CLEAR: begin
            // Terminal test before increment, so cnt never wraps.
            if (cnt_q == LAST) begin
               state_n = S_IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // ---------------- clear engine: outputs ----------------
   // A reset in a clear cycle blocks that cycle's clear write, so an
   // aborted clear leaves exactly the entries before cnt cleared.
   always_comb begin
      clear_busy = (state_q == S_CLEAR);
      clr_act    = clear_busy && !reset;
      wr_dropped = clr_act && wea && (banka == cbank_q);
      clear_done = done_q;
   end

   // ---------------- banks ----------------
   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: DEF};
      logic                  we;
      logic [AW-1:0]         wa;
      logic [DATA_WIDTH-1:0] wd;
      logic                  hit;
      logic [DATA_WIDTH-1:0] rd_val;

      // The clear engine owns the bank while it is being cleared.
      always_comb begin
         we = 1'b0;
         wa = addra;
         wd = dia;
         if (clr_act && (cbank_q == BANK_WIDTH'(i))) begin
            we = 1'b1;
            wa = cnt_q;
            wd = DEF;
         end else if (wea && (banka == BANK_WIDTH'(i))) begin
            we = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (we) mem[wa] <= wd;
      end

`ifdef MEM_MULTI_BANK_CLR_BYPASS_EN
      // wa/wd already describe the effective write, so a dropped
      // user write is never forwarded.
      assign hit = we && (wa == addrb);
`else
      assign hit = 1'b0;
`endif

      assign rd_val = hit ? wd : mem[addrb];

      if (OUTPUT_DELAY > 0) begin : g_q
         logic                  re;
         logic [DATA_WIDTH-1:0] q;
         assign re = reb && (bankb == BANK_WIDTH'(i));
         always_ff @(posedge clk) begin
            if (re) q <= rd_val;
         end
         assign bank_out[i] = q;
      end else begin : g_c
         assign bank_out[i] = rd_val;
      end
   end

   // ---------------- read output pipeline ----------------
   if (OUTPUT_DELAY == 0) begin : g_od0
      assign dob       = bank_out[bankb];
      assign dob_valid = reb;
   end else begin : g_odn
      logic [BANK_WIDTH-1:0] bank_d1;
      logic                  v1;

      always_ff @(posedge clk) begin
         if (reset) v1 <= 1'b0;
         else       v1 <= reb;
         if (reb) bank_d1 <= bankb;
      end

      if (OUTPUT_DELAY == 1) begin : g_od1
         assign dob       = bank_out[bank_d1];
         assign dob_valid = v1;
      end else begin : g_od2
         logic [DATA_WIDTH-1:0] s2;
         logic                  v2;
         always_ff @(posedge clk) begin
            if (reset) v2 <= 1'b0;
            else       v2 <= v1;
            if (v1) s2 <= bank_out[bank_d1];
         end
         assign dob       = s2;
         assign dob_valid = v2;
      end
   end

endmodule

// File: tb/tb_mem_multi_bank_clr.sv
// tb_mem_multi_bank_clr: directed bench for mem_multi_bank_clr.
// u_a uses OUTPUT_DELAY=1 and u_b uses OUTPUT_DELAY=2; both have 4 banks x 16.
module tb_mem_multi_bank_clr;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic       a_wea = 0, a_reb = 0, a_clear_req = 0;
   logic [1:0] a_banka = 0, a_bankb = 0, a_clear_bank = 0;
   logic [3:0] a_addra = 0, a_addrb = 0;
   logic [7:0] a_dia = 0;
   logic [7:0] a_dob;
   logic       a_dob_valid, a_clear_busy, a_clear_done, a_wr_dropped;

   logic       b_wea = 0, b_reb = 0, b_clear_req = 0;
   logic [1:0] b_banka = 0, b_bankb = 0, b_clear_bank = 0;
   logic [3:0] b_addra = 0, b_addrb = 0;
   logic [7:0] b_dia = 0;
   logic [7:0] b_dob;
   logic       b_dob_valid, b_clear_busy, b_clear_done, b_wr_dropped;

   logic [7:0] model [4][16];

   mem_multi_bank_clr #(
      .DATA_WIDTH(8), .DEPTH(16), .NUM_BANKS(4),
      .OUTPUT_DELAY(1), .DEFAULT_VALUE(0)
   ) u_a (
      .clk(clk), .reset(reset),
      .wea(a_wea), .banka(a_banka), .addra(a_addra), .dia(a_dia),
      .reb(a_reb), .bankb(a_bankb), .addrb(a_addrb),
      .dob(a_dob), .dob_valid(a_dob_valid),
      .clear_req(a_clear_req), .clear_bank(a_clear_bank),
      .clear_busy(a_clear_busy), .clear_done(a_clear_done),
      .wr_dropped(a_wr_dropped)
   );

   mem_multi_bank_clr #(
      .DATA_WIDTH(8), .DEPTH(16), .NUM_BANKS(4),
      .OUTPUT_DELAY(2), .DEFAULT_VALUE(0)
   ) u_b (
      .clk(clk), .reset(reset),
      .wea(b_wea), .banka(b_banka), .addra(b_addra), .dia(b_dia),
      .reb(b_reb), .bankb(b_bankb), .addrb(b_addrb),
      .dob(b_dob), .dob_valid(b_dob_valid),
      .clear_req(b_clear_req), .clear_bank(b_clear_bank),
      .clear_busy(b_clear_busy), .clear_done(b_clear_done),
      .wr_dropped(b_wr_dropped)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input [1:0] bk, input [3:0] ad, input [7:0] d);
      a_wea = 1; a_banka = bk; a_addra = ad; a_dia = d;
      step();
      a_wea = 0;
   endtask

   task automatic rd_a(input [1:0] bk, input [3:0] ad,
                       output [7:0] d, output v);
      a_reb = 1; a_bankb = bk; a_addrb = ad;
      step();
      a_reb = 0;
      d = a_dob; v = a_dob_valid;
   endtask

   task automatic wr_b(input [1:0] bk, input [3:0] ad, input [7:0] d);
      b_wea = 1; b_banka = bk; b_addra = ad; b_dia = d;
      step();
      b_wea = 0;
   endtask

   task automatic rd_b(input [1:0] bk, input [3:0] ad,
                       output [7:0] d, output v);
      b_reb = 1; b_bankb = bk; b_addrb = ad;
      step();
      b_reb = 0;
      step();
      d = b_dob; v = b_dob_valid;
   endtask

   task automatic pulse_clear_a(input [1:0] bk);
      a_clear_req = 1; a_clear_bank = bk;
      step();
      a_clear_req = 0;
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (3) step();
      total++;
      if ({a_clear_busy, a_clear_done, a_wr_dropped, a_dob_valid} !== 4'b0) begin
         bad++;
         $display("FAIL reset_a busy/done/drop/valid=%b want 0000",
                  {a_clear_busy, a_clear_done, a_wr_dropped, a_dob_valid});
      end
      total++;
      if ({b_clear_busy, b_clear_done, b_wr_dropped, b_dob_valid} !== 4'b0) begin
         bad++;
         $display("FAIL reset_b busy/done/drop/valid=%b want 0000",
                  {b_clear_busy, b_clear_done, b_wr_dropped, b_dob_valid});
      end
      reset = 0;
      step();
   endtask

   task automatic test_write_read;
      logic [7:0] d;
      logic v;
      wr_a(2, 3, 8'hA5);
      rd_a(2, 3, d, v);
      total++;
      if (d !== 8'hA5 || v !== 1'b1) begin
         bad++;
         $display("FAIL wr_rd b2a3 got %h/%b want a5/1", d, v);
      end
      step();
      total++;
      if (a_dob_valid !== 1'b0) begin
         bad++;
         $display("FAIL valid_pulse got %b want 0", a_dob_valid);
      end
      rd_a(1, 3, d, v);
      total++;
      if (d !== 8'h00 || v !== 1'b1) begin
         bad++;
         $display("FAIL default b1a3 got %h/%b want 00/1", d, v);
      end
   endtask

   task automatic test_clear;
      logic [7:0] d;
      logic v;
      int nb, nd, dpos;
      for (int i = 0; i < 16; i++) wr_a(1, 4'(i), 8'(i));
      for (int i = 0; i < 16; i++) wr_a(0, 4'(i), 8'hF0 | 8'(i));
      pulse_clear_a(1);
      nb = 0; nd = 0; dpos = -1;
      for (int k = 0; k < 40; k++) begin
         if (a_clear_busy) nb++;
         if (a_clear_done) begin nd++; dpos = k; end
         step();
      end
      total++;
      if (nb != 16) begin
         bad++;
         $display("FAIL clr_busy_len got %0d want 16", nb);
      end
      total++;
      if (nd != 1 || dpos != 16) begin
         bad++;
         $display("FAIL clr_done got n=%0d pos=%0d want n=1 pos=16", nd, dpos);
      end
      for (int i = 0; i < 16; i++) begin
         rd_a(1, 4'(i), d, v);
         total++;
         if (d !== 8'h00 || v !== 1'b1) begin
            bad++;
            $display("FAIL clr_b1 a%0d got %h/%b want 00/1", i, d, v);
         end
      end
      for (int i = 0; i < 16; i++) begin
         rd_a(0, 4'(i), d, v);
         total++;
         if (d !== (8'hF0 | 8'(i))) begin
            bad++;
            $display("FAIL keep_b0 a%0d got %h want %h", i, d, 8'hF0 | 8'(i));
         end
      end
   endtask

   task automatic test_drop;
      logic [7:0] d;
      logic v;
      pulse_clear_a(1);
      repeat (8) step();
      a_wea = 1; a_banka = 1; a_addra = 5; a_dia = 8'h33;
      @(negedge clk);
      total++;
      if (a_wr_dropped !== 1'b1) begin
         bad++;
         $display("FAIL drop_b1 got %b want 1", a_wr_dropped);
      end
      step();
      a_banka = 0; a_dia = 8'h44;
      @(negedge clk);
      total++;
      if (a_wr_dropped !== 1'b0) begin
         bad++;
         $display("FAIL drop_b0 got %b want 0", a_wr_dropped);
      end
      step();
      a_wea = 0;
      for (int k = 0; k < 30 && a_clear_busy; k++) step();
      total++;
      if (a_clear_busy !== 1'b0) begin
         bad++;
         $display("FAIL drop_wait busy=%b want 0", a_clear_busy);
      end
      rd_a(1, 5, d, v);
      total++;
      if (d !== 8'h00) begin
         bad++;
         $display("FAIL drop_b1a5 got %h want 00", d);
      end
      rd_a(0, 5, d, v);
      total++;
      if (d !== 8'h44) begin
         bad++;
         $display("FAIL keep_b0a5 got %h want 44", d);
      end
   endtask

   task automatic test_reset_abort;
      logic [7:0] d, e;
      logic v;
      int nd;
      for (int i = 0; i < 16; i++) wr_a(1, 4'(i), 8'h50 + 8'(i));
      pulse_clear_a(1);
      repeat (7) step();
      reset = 1;
      step();
      reset = 0;
      total++;
      if (a_clear_busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_busy got %b want 0", a_clear_busy);
      end
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         if (a_clear_done) nd++;
         step();
      end
      total++;
      if (nd != 0) begin
         bad++;
         $display("FAIL abort_done got %0d want 0", nd);
      end
      for (int i = 0; i < 16; i++) begin
         e = (i < 7) ? 8'h00 : 8'h50 + 8'(i);
         rd_a(1, 4'(i), d, v);
         total++;
         if (d !== e) begin
            bad++;
            $display("FAIL abort_b1 a%0d got %h want %h", i, d, e);
         end
      end
      pulse_clear_a(1);
      total++;
      if (a_clear_busy !== 1'b1) begin
         bad++;
         $display("FAIL reclear_busy got %b want 1", a_clear_busy);
      end
      nd = 0;
      for (int k = 0; k < 30 && nd == 0; k++) begin
         if (a_clear_done) nd++;
         step();
      end
      total++;
      if (nd != 1) begin
         bad++;
         $display("FAIL reclear_done got %0d want 1", nd);
      end
      rd_a(1, 10, d, v);
      total++;
      if (d !== 8'h00) begin
         bad++;
         $display("FAIL reclear_b1a10 got %h want 00", d);
      end
   endtask

   task automatic test_same_cycle;
      logic [7:0] d, e;
      logic v;
`ifdef MEM_MULTI_BANK_CLR_BYPASS_EN
      e = 8'h7E;
`else
      e = 8'h11;
`endif
      wr_a(3, 0, 8'h11);
      a_wea = 1; a_banka = 3; a_addra = 0; a_dia = 8'h7E;
      a_reb = 1; a_bankb = 3; a_addrb = 0;
      step();
      a_wea = 0; a_reb = 0;
      total++;
      if (a_dob !== e || a_dob_valid !== 1'b1) begin
         bad++;
         $display("FAIL same_cycle got %h/%b want %h/1", a_dob, a_dob_valid, e);
      end
      rd_a(3, 0, d, v);
      total++;
      if (d !== 8'h7E) begin
         bad++;
         $display("FAIL after_same got %h want 7e", d);
      end
   endtask

   task automatic test_od2_random;
      logic       ev1, ev2;
      logic [7:0] ed1, ed2, rv;
      logic       iss;
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 16; a++) begin
            rv = 8'(b * 37 + a * 11 + 3);
            model[b][a] = rv;
            wr_b(2'(b), 4'(a), rv);
         end
      ev1 = 0; ev2 = 0; ed1 = 0; ed2 = 0;
      for (int k = 0; k < 64; k++) begin
         iss = (k < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
         b_reb = iss;
         b_bankb = 2'($urandom_range(0, 3));
         b_addrb = 4'($urandom_range(0, 15));
         rv = model[b_bankb][b_addrb];
         step();
         ev2 = ev1; ed2 = ed1;
         ev1 = iss; ed1 = rv;
         total++;
         if (b_dob_valid !== ev2 || (ev2 && b_dob !== ed2)) begin
            bad++;
            $display("FAIL od2_rd k=%0d got %h/%b want %h/%b",
                     k, b_dob, b_dob_valid, ed2, ev2);
         end
      end
      b_reb = 0;
   endtask

   task automatic test_clear_ignored;
      logic [7:0] d;
      logic v;
      int nb, nd;
      b_clear_req = 1; b_clear_bank = 2;
      step();
      b_clear_req = 0;
      nb = 0; nd = 0;
      for (int k = 0; k < 40; k++) begin
         b_clear_req = (k == 5);
         b_clear_bank = 3;
         if (b_clear_busy) nb++;
         if (b_clear_done) nd++;
         step();
      end
      b_clear_req = 0;
      total++;
      if (nb != 16 || nd != 1) begin
         bad++;
         $display("FAIL ign_req busy=%0d done=%0d want 16/1", nb, nd);
      end
      for (int a = 0; a < 16; a++) model[2][a] = 8'h00;
      for (int a = 0; a < 16; a += 5) begin
         rd_b(2, 4'(a), d, v);
         total++;
         if (d !== model[2][a] || v !== 1'b1) begin
            bad++;
            $display("FAIL ign_b2 a%0d got %h/%b want %h/1", a, d, v, model[2][a]);
         end
         rd_b(3, 4'(a), d, v);
         total++;
         if (d !== model[3][a] || v !== 1'b1) begin
            bad++;
            $display("FAIL ign_b3 a%0d got %h/%b want %h/1", a, d, v, model[3][a]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_clear();
      test_drop();
      test_reset_abort();
      test_same_cycle();
      test_od2_random();
      test_clear_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_multi_bank_clr.md
# mem_multi_bank_clr

Multi-bank simple-dual-port memory with NUM_BANKS independent banks sharing one write port and one read port, selectable read latency, and a built-in bank clear engine. A clear writes DEFAULT_VALUE to every entry of one bank, one entry per cycle, without stalling traffic to the other banks. It sits wherever per-channel operator/envelope state is held per bank and must be re-initialised at runtime, such as on a chip-mode change or a note reset.

## Interface
- DATA_WIDTH, 8: width of each entry.
- DEPTH, 16: entries per bank; a power of two, ≥2.
- NUM_BANKS, 2: number of banks, ≥2.
- BANK_WIDTH, $clog2(NUM_BANKS): width of the bank select.
- OUTPUT_DELAY, 1: read latency; 0, 1 or 2.
- DEFAULT_VALUE, 0: power-up and clear value of every entry.

- clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wea  in  1  user write enable.
- banka  in  BANK_WIDTH  write bank.
- addra  in  $clog2(DEPTH)  write address.
- dia  in  DATA_WIDTH  write data.
- reb  in  1  read enable.
- bankb  in  BANK_WIDTH  read bank.
- addrb  in  $clog2(DEPTH)  read address.
- dob  out  DATA_WIDTH  read data.
- dob_valid  out  1  dob carries the data for a reb issued OUTPUT_DELAY cycles earlier.
- clear_req  in  1  start clearing clear_bank; single-cycle pulse.
- clear_bank  in  BANK_WIDTH  bank to clear, sampled with clear_req.
- clear_busy  out  1  clear engine active.
- clear_done  out  1  one-cycle pulse after the last entry is cleared.
- wr_dropped  out  1  one-cycle pulse: a user write was discarded.

## Operation
- Each bank is one simple-dual-port RAM; all entries are initialised to DEFAULT_VALUE at configuration.
- Write select: bank i is written when (clearing bank i) or (wea and banka==i).
- Clear writes take priority. A user write to the bank being cleared is discarded, and wr_dropped pulses in the same cycle. User writes to other banks proceed normally.
- Read select: reb is gated to bankb only. The output mux uses bankb delayed by OUTPUT_DELAY cycles.
- dob for an unaddressed, non-enabled cycle is don't-care. Benches check dob only when dob_valid=1.
- State machine:
  - IDLE → CLEAR on clear_req. Latch clear_bank into cbank and set cnt=0.
  - CLEAR: write DEFAULT_VALUE to cbank[cnt] each cycle and increment cnt.
  - CLEAR → IDLE in the cycle after cnt==DEPTH-1 is written. clear_done pulses in that transition cycle.
- clear_req while busy is ignored; there is no queuing.
- clear_req in the same cycle as a user write to clear_bank: the user write completes, because the engine is not yet active.
- Reads of the bank being cleared return the current contents, cleared or not. No stall.
- Reset: state IDLE, cnt=0, clear_busy=0, clear_done=0, wr_dropped=0, dob_valid pipeline=0.
- Memory contents are not touched by reset. A reset in the middle of a clear aborts it and leaves the bank partially cleared; no clear_done is issued.
- Same bank/address read and write in one cycle, macro absent: read-first, so the read returns the old data.

## Timing
- OUTPUT_DELAY=0: dob is combinational from bankb/addrb, and dob_valid=reb.
- OUTPUT_DELAY=1: data appears one cycle after reb.
- OUTPUT_DELAY=2: data appears two cycles after reb. The second stage is a register enabled by the delayed reb.
- A write becomes visible to reads issued on the next cycle onward.
- Clear duration: clear_busy is high for exactly DEPTH cycles, starting the cycle after clear_req. clear_done is high in the cycle after the last clear write.
- cnt is $clog2(DEPTH) bits. The terminal condition is compared before wrap, so cnt never wraps.
- The earliest accepted back-to-back clear_req is in the clear_done cycle, since the engine is IDLE in that cycle.

## Configuration
- MEM_MULTI_BANK_CLR_BYPASS_EN defined: write-to-read forwarding is enabled. A reb with bankb==banka and addrb==addra while a write to that location is effective returns dia. This includes a clear write, which returns DEFAULT_VALUE. Forwarded data is delayed by OUTPUT_DELAY like normal read data. A dropped user write is never forwarded.
- MEM_MULTI_BANK_CLR_BYPASS_EN absent: no forwarding, read-first behaviour.

## Test plan
- DEPTH=16, NUM_BANKS=4, OUTPUT_DELAY=1: write 0xA5 to bank2/addr3, then read bank2/addr3 the next cycle → dob=0xA5 with dob_valid=1 one cycle later. Reading bank1/addr3 → DEFAULT_VALUE.
- Fill bank1 with its address values, then pulse clear_req on bank1 → clear_busy high for 16 cycles, clear_done pulses once, and all 16 reads return 0. Bank0 data is unchanged.
- During a bank1 clear: write bank1/addr5=0x33 → wr_dropped=1. Write bank0/addr5=0x44 → accepted. After the clear, bank1/addr5=0 and bank0/addr5=0x44.
- Assert reset at clear cycle 7 → clear_busy=0 next cycle and no clear_done. Entries 0–6 are cleared and the rest are unchanged. A new clear_req is accepted afterwards.
- OUTPUT_DELAY=2: random reads across all banks and addresses vs. a reference model → dob and dob_valid match at a 2-cycle lag. A second clear_req while busy is ignored.
- Same-cycle write 0x7E and read to bank3/addr0 (old value 0x11) → 0x11 without the macro, 0x7E with MEM_MULTI_BANK_CLR_BYPASS_EN.
